// File: rtl/data_mem_load_seq_pkg.sv
// Shared definitions for the data-memory load/store paths: FSM encoding,
// default widths and lane indices.
package dmem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Lane numbering as seen by the issue logic; the store buffer uses the same indices.
    localparam int LANE_LD3 = 3;
    localparam int LANE_LD4 = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_L4   = 1'b1
    } state_t;

    // Two loads need two port cycles unless they target the same word.
    function automatic logic needs_two_reads(input logic rd3, input logic rd4,
                                             input logic addr_eq);
        return rd3 && rd4 && !addr_eq;
    endfunction

endpackage

// File: rtl/data_mem_load_seq_if.sv
// Read side of the shared data-memory port, arbitrated against the store drain.
interface data_mem_load_seq_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          mem_req;
    logic [AW-1:0] mem_raddr;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_raddr,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_raddr,
        output mem_gnt,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_load_seq.sv
// Serialises the two M-stage loads onto the single shared read port and
// presents both results together in W, stalling the pipe while it works.
module data_mem_load_seq
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemReadM3,
    input  logic [AW-1:0]        alu_resultM3,
    input  logic                 MemReadM4,
    input  logic [AW-1:0]        alu_resultM4,
    output logic                 stall,
    data_mem_load_seq_if.master  mem,
    output logic [DW-1:0]        read_dataW3,
    output logic [DW-1:0]        read_dataW4,
    output logic                 read_validW3,
    output logic                 read_validW4
);

    state_t        state_q, state_d;
    logic          req;
    logic [AW-1:0] raddr;
    logic          addr_eq;
    logic          vld3_d, vld4_d, sel3_d, enter_l4;
    logic          entry_p1;
    logic          sel3_p1;
    logic [DW-1:0] hold3_p1;

    assign addr_eq = (alu_resultM3 == alu_resultM4);

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        raddr    = alu_resultM3;
        stall    = 1'b0;
        vld3_d   = 1'b0;
        vld4_d   = 1'b0;
        sel3_d   = 1'b0;
        enter_l4 = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (needs_two_reads(MemReadM3, MemReadM4, addr_eq)) begin
                    req   = 1'b1;
                    raddr = alu_resultM3;
                    stall = 1'b1;
                    if (mem.mem_gnt) begin
                        state_d  = S_L4;
                        enter_l4 = 1'b1;
                    end
                end else if (MemReadM3 || MemReadM4) begin
                    // Equal-address pair collapses to one read serving both lanes.
                    req   = 1'b1;
                    raddr = MemReadM3 ? alu_resultM3 : alu_resultM4;
                    stall = ~mem.mem_gnt;
                    if (mem.mem_gnt) begin
                        vld3_d = MemReadM3;
                        vld4_d = MemReadM4;
                    end
                end
            end
            S_L4: begin
                req   = 1'b1;
                raddr = alu_resultM4;
                stall = ~mem.mem_gnt;
                if (mem.mem_gnt) begin
                    state_d = S_IDLE;
                    vld3_d  = 1'b1;
                    vld4_d  = 1'b1;
                    sel3_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_raddr = raddr;

    // W stage: lane 3 comes from the holding register only after a split pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            read_validW3 <= 1'b0;
            read_validW4 <= 1'b0;
            sel3_p1      <= 1'b0;
            entry_p1     <= 1'b0;
            hold3_p1     <= '0;
        end else begin
            state_q      <= state_d;
            read_validW3 <= vld3_d;
            read_validW4 <= vld4_d;
            sel3_p1      <= sel3_d;
            entry_p1     <= enter_l4;
            if (entry_p1)
                hold3_p1 <= mem.mem_rdata;
        end
    end

    assign read_dataW3 = sel3_p1 ? hold3_p1 : mem.mem_rdata;
    assign read_dataW4 = mem.mem_rdata;

endmodule

// File: tb/tb_data_mem_load_seq.sv
// Cycle-trace bench for the load sequencer with a one-cycle-latency memory model.
module tb_data_mem_load_seq;

    typedef struct {
        logic        rd3;
        logic [31:0] a3;
        logic        rd4;
        logic [31:0] a4;
        logic        gnt;
        logic        stall;
        logic        req;
        logic [31:0] raddr;
        logic        v3;
        logic        v4;
        logic [31:0] d3;
        logic [31:0] d4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM3 = 1'b0;
    logic [31:0] alu_resultM3 = '0;
    logic        MemReadM4 = 1'b0;
    logic [31:0] alu_resultM4 = '0;
    logic        stall;
    logic [31:0] read_dataW3, read_dataW4;
    logic        read_validW3, read_validW4;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[20];

    data_mem_load_seq_if #(.AW(32), .DW(32)) mif ();

    data_mem_load_seq #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadM3    (MemReadM3),
        .alu_resultM3 (alu_resultM3),
        .MemReadM4    (MemReadM4),
        .alu_resultM4 (alu_resultM4),
        .stall        (stall),
        .mem          (mif),
        .read_dataW3  (read_dataW3),
        .read_dataW4  (read_dataW4),
        .read_validW3 (read_validW3),
        .read_validW4 (read_validW4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEADBEEF;
            32'h10:  return 32'h11111111;
            32'h20:  return 32'h22222222;
            32'h30:  return 32'h33333333;
            32'h50:  return 32'h55555555;
            32'h60:  return 32'h66666666;
            default: return ~a;
        endcase
    endfunction

    // Ungranted cycles return junk so stale captures show up.
    initial mif.mem_rdata = 32'h0BADF00D;
    always @(posedge clk) begin
        if (mif.mem_req && mif.mem_gnt)
            mif.mem_rdata <= memval(mif.mem_raddr);
        else
            mif.mem_rdata <= 32'h0BADF00D;
    end

    function automatic vec_t mk(input logic rd3, input logic [31:0] a3,
                                input logic rd4, input logic [31:0] a4,
                                input logic gnt, input logic st, input logic rq,
                                input logic [31:0] ra, input logic v3, input logic v4,
                                input logic [31:0] d3, input logic [31:0] d4);
        vec_t v;
        v.rd3 = rd3; v.a3 = a3; v.rd4 = rd4; v.a4 = a4; v.gnt = gnt;
        v.stall = st; v.req = rq; v.raddr = ra;
        v.v3 = v3; v.v4 = v4; v.d3 = d3; v.d4 = d4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance to next posedge+1.
    task automatic apply(input vec_t v, input string tag);
        MemReadM3    = v.rd3;
        alu_resultM3 = v.a3;
        MemReadM4    = v.rd4;
        alu_resultM4 = v.a4;
        mif.mem_gnt  = v.gnt;
        @(negedge clk);
        chk({tag, " stall"}, {31'd0, stall}, {31'd0, v.stall});
        chk({tag, " mem_req"}, {31'd0, mif.mem_req}, {31'd0, v.req});
        if (v.req)
            chk({tag, " mem_raddr"}, mif.mem_raddr, v.raddr);
        chk({tag, " validW3"}, {31'd0, read_validW3}, {31'd0, v.v3});
        chk({tag, " validW4"}, {31'd0, read_validW4}, {31'd0, v.v4});
        if (v.v3)
            chk({tag, " dataW3"}, read_dataW3, v.d3);
        if (v.v4)
            chk({tag, " dataW4"}, read_dataW4, v.d4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rd3 a3     rd4 a4     gnt stall req raddr  v3 v4 d3            d4
        tbl[0]  = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  0, 0, 32'h0,        32'h0);
        tbl[1]  = mk(1, 32'h40, 0, 32'h0,  1, 0, 1, 32'h40, 0, 0, 32'h0,        32'h0);
        tbl[2]  = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  1, 0, 32'hDEADBEEF, 32'h0);
        tbl[3]  = mk(1, 32'h10, 1, 32'h20, 1, 1, 1, 32'h10, 0, 0, 32'h0,        32'h0);
        tbl[4]  = mk(1, 32'h10, 1, 32'h20, 1, 0, 1, 32'h20, 0, 0, 32'h0,        32'h0);
        tbl[5]  = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  1, 1, 32'h11111111, 32'h22222222);
        tbl[6]  = mk(1, 32'h30, 1, 32'h30, 1, 0, 1, 32'h30, 0, 0, 32'h0,        32'h0);
        tbl[7]  = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  1, 1, 32'h33333333, 32'h33333333);
        tbl[8]  = mk(1, 32'h10, 1, 32'h20, 0, 1, 1, 32'h10, 0, 0, 32'h0,        32'h0);
        tbl[9]  = mk(1, 32'h10, 1, 32'h20, 0, 1, 1, 32'h10, 0, 0, 32'h0,        32'h0);
        tbl[10] = mk(1, 32'h10, 1, 32'h20, 1, 1, 1, 32'h10, 0, 0, 32'h0,        32'h0);
        tbl[11] = mk(1, 32'h10, 1, 32'h20, 0, 1, 1, 32'h20, 0, 0, 32'h0,        32'h0);
        tbl[12] = mk(1, 32'h10, 1, 32'h20, 1, 0, 1, 32'h20, 0, 0, 32'h0,        32'h0);
        tbl[13] = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  1, 1, 32'h11111111, 32'h22222222);
        tbl[14] = mk(1, 32'h50, 0, 32'h0,  1, 0, 1, 32'h50, 0, 0, 32'h0,        32'h0);
        tbl[15] = mk(0, 32'h0,  1, 32'h60, 1, 0, 1, 32'h60, 1, 0, 32'h55555555, 32'h0);
        tbl[16] = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  0, 1, 32'h0,        32'h66666666);
        tbl[17] = mk(1, 32'h40, 0, 32'h0,  0, 1, 1, 32'h40, 0, 0, 32'h0,        32'h0);
        tbl[18] = mk(1, 32'h40, 0, 32'h0,  1, 0, 1, 32'h40, 0, 0, 32'h0,        32'h0);
        tbl[19] = mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  1, 0, 32'hDEADBEEF, 32'h0);

        // Reset holds the port quiet even with loads presented.
        mif.mem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        MemReadM3    = 1'b1;
        alu_resultM3 = 32'h40;
        @(negedge clk);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst validW3", {31'd0, read_validW3}, 32'd0);
        chk("rst validW4", {31'd0, read_validW4}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Abort a split pair while in L4; the next load must restart from IDLE.
        apply(mk(1, 32'h10, 1, 32'h20, 1, 1, 1, 32'h10, 0, 0, 32'h0, 32'h0), "abort0");
        rst = 1'b1;
        apply(mk(1, 32'h10, 1, 32'h20, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0), "abort1");
        rst = 1'b0;
        apply(mk(1, 32'h40, 0, 32'h20, 1, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0), "abort2");
        apply(mk(0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0), "abort3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
